// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: merges the never-stalled WB stage with a
// FIFO-buffered long-latency-unit result stream, and tracks outstanding LLU destinations.
module rf_wb_ctrl #(
   parameter int DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_wb_valid,
   input  logic [4:0]               i_wb_rd,
   input  logic [31:0]              i_wb_data,
   input  logic                     i_issue_valid,
   input  logic [4:0]               i_issue_rd,
   input  logic                     i_llu_valid,
   input  logic [4:0]               i_llu_rd,
   input  logic [31:0]              i_llu_data,
   output logic                     o_llu_ready,
   input  logic [4:0]               i_rs1_addr,
   input  logic [4:0]               i_rs2_addr,
   output logic                     o_busy_rs1,
   output logic                     o_busy_rs2,
   output logic [4:0]               o_rd_addr,
   output logic [31:0]              o_rd_data,
   output logic                     o_rd_wren,
   output logic [31:0]              o_pending,
   output logic [$clog2(DEPTH):0]   o_fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [4:0]       fifo_rd   [DEPTH];
   logic [31:0]      fifo_data [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [31:0]      pending;
   logic [31:0]      pending_nxt;
   logic             push;
   logic             pop;
   logic [4:0]       head_rd;

   assign head_rd     = fifo_rd[rd_ptr];
   // Ready looks only at registered count, so a same-cycle pop never raises it.
   assign o_llu_ready = i_reset && (count != CNT_W'(DEPTH));
   assign push        = i_llu_valid && o_llu_ready;
   assign pop         = i_reset && !i_wb_valid && (count != '0);

   always_comb begin
      o_rd_wren = 1'b0;
      o_rd_addr = 5'd0;
      o_rd_data = 32'd0;
      if (i_reset && i_wb_valid) begin
         o_rd_wren = 1'b1;
         o_rd_addr = i_wb_rd;
         o_rd_data = i_wb_data;
      end else if (pop) begin
         o_rd_wren = 1'b1;
         o_rd_addr = head_rd;
         o_rd_data = fifo_data[rd_ptr];
      end
   end

   // Clear on pop first so a same-cycle issue to that register (newer op) wins.
   always_comb begin
      pending_nxt = pending;
      if (pop)
         pending_nxt[head_rd] = 1'b0;
      if (i_issue_valid && (i_issue_rd != 5'd0))
         pending_nxt[i_issue_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= i_llu_rd;
         fifo_data[wr_ptr] <= i_llu_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         pending <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         pending <= pending_nxt;
      end
   end

   assign o_busy_rs1 = i_reset && (i_rs1_addr != 5'd0) && pending[i_rs1_addr] &&
                       !(pop && (head_rd == i_rs1_addr));
   assign o_busy_rs2 = i_reset && (i_rs2_addr != 5'd0) && pending[i_rs2_addr] &&
                       !(pop && (head_rd == i_rs2_addr));
   assign o_pending    = pending;
   assign o_fifo_count = count;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: a monitor pairs every register-file write with the
// expected WB or LLU entry queued when the stimulus was issued.
module tb_rf_wb_ctrl;

   logic        i_clk;
   logic        i_reset;
   logic        i_wb_valid;
   logic [4:0]  i_wb_rd;
   logic [31:0] i_wb_data;
   logic        i_issue_valid;
   logic [4:0]  i_issue_rd;
   logic        i_llu_valid;
   logic [4:0]  i_llu_rd;
   logic [31:0] i_llu_data;
   logic        o_llu_ready;
   logic [4:0]  i_rs1_addr;
   logic [4:0]  i_rs2_addr;
   logic        o_busy_rs1;
   logic        o_busy_rs2;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic        o_rd_wren;
   logic [31:0] o_pending;
   logic [1:0]  o_fifo_count;

   int total = 0;
   int bad   = 0;

   logic [36:0] wb_q[$];
   logic [36:0] llu_q[$];

   rf_wb_ctrl #(.DEPTH(2)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
      .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
      .i_llu_valid(i_llu_valid), .i_llu_rd(i_llu_rd), .i_llu_data(i_llu_data),
      .o_llu_ready(o_llu_ready),
      .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
      .o_busy_rs1(o_busy_rs1), .o_busy_rs2(o_busy_rs2),
      .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren),
      .o_pending(o_pending), .o_fifo_count(o_fifo_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] data);
      i_wb_valid = 1'b1;
      i_wb_rd    = rd;
      i_wb_data  = data;
      wb_q.push_back({rd, data});
   endtask

   task automatic llu(input logic [4:0] rd, input logic [31:0] data);
      i_llu_valid = 1'b1;
      i_llu_rd    = rd;
      i_llu_data  = data;
      llu_q.push_back({rd, data});
   endtask

   task automatic idle();
      i_wb_valid    = 1'b0;
      i_llu_valid   = 1'b0;
      i_issue_valid = 1'b0;
   endtask

   // Write-port monitor: WB owns the port whenever it is valid, otherwise any write is an LLU pop.
   always @(negedge i_clk) begin
      logic [36:0] e;
      if (i_reset) begin
         if (i_wb_valid) begin
            chk("wb_wren", 32'(o_rd_wren), 32'd1);
            if (wb_q.size() == 0) begin
               chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
               e = wb_q.pop_front();
               chk("wb_addr", 32'(o_rd_addr), 32'(e[36:32]));
               chk("wb_data", o_rd_data, e[31:0]);
            end
         end else if (o_rd_wren) begin
            if (llu_q.size() == 0) begin
               chk("llu_unexpected", 32'd1, 32'd0);
            end else begin
               e = llu_q.pop_front();
               chk("llu_addr", 32'(o_rd_addr), 32'(e[36:32]));
               chk("llu_data", o_rd_data, e[31:0]);
            end
         end
      end
   end

   initial begin
      // Reset held with every input active.
      i_reset = 1'b0;
      i_wb_valid = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'hFFFF_FFFF;
      i_issue_valid = 1'b1; i_issue_rd = 5'd5;
      i_llu_valid = 1'b1; i_llu_rd = 5'd6; i_llu_data = 32'h5555_5555;
      i_rs1_addr = 5'd5; i_rs2_addr = 5'd6;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_wren",  32'(o_rd_wren), 32'd0);
      chk("rst_addr",  32'(o_rd_addr), 32'd0);
      chk("rst_data",  o_rd_data, 32'd0);
      chk("rst_ready", 32'(o_llu_ready), 32'd0);
      chk("rst_busy1", 32'(o_busy_rs1), 32'd0);
      chk("rst_busy2", 32'(o_busy_rs2), 32'd0);
      chk("rst_pend",  o_pending, 32'd0);
      chk("rst_count", 32'(o_fifo_count), 32'd0);
      tick();
      idle();
      i_rs1_addr = 5'd0; i_rs2_addr = 5'd0;
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("rel_ready", 32'(o_llu_ready), 32'd1);
      chk("rel_count", 32'(o_fifo_count), 32'd0);
      chk("rel_wren",  32'(o_rd_wren), 32'd0);

      // WB only.
      tick();
      wb(5'd5, 32'hDEAD_BEEF);
      @(negedge i_clk);
      chk("wbonly_count", 32'(o_fifo_count), 32'd0);
      tick();
      idle();

      // LLU round trip on x7.
      i_issue_valid = 1'b1; i_issue_rd = 5'd7;
      tick();
      i_issue_valid = 1'b0; i_rs1_addr = 5'd7;
      llu(5'd7, 32'h0000_1234);
      @(negedge i_clk);
      chk("rt_pend7", 32'(o_pending[7]), 32'd1);
      chk("rt_busy",  32'(o_busy_rs1), 32'd1);
      tick();
      idle();
      @(negedge i_clk);
      chk("rt_wren",     32'(o_rd_wren), 32'd1);
      chk("rt_busy_pop", 32'(o_busy_rs1), 32'd0);
      tick();
      @(negedge i_clk);
      chk("rt_pend7_clr", 32'(o_pending[7]), 32'd0);
      chk("rt_count",     32'(o_fifo_count), 32'd0);

      // WB held while LLU fills the FIFO.
      tick();
      wb(5'd10, 32'h0000_00A0); llu(5'd3, 32'h0000_0333);
      tick();
      wb(5'd11, 32'h0000_00B1); llu(5'd4, 32'h0000_0444);
      tick();
      wb(5'd12, 32'h0000_00C2);
      i_llu_valid = 1'b1; i_llu_rd = 5'd5; i_llu_data = 32'h0000_0555;
      @(negedge i_clk);
      chk("bp_count", 32'(o_fifo_count), 32'd2);
      chk("bp_ready", 32'(o_llu_ready), 32'd0);
      tick();
      idle();
      @(negedge i_clk);
      chk("drain_addr3", 32'(o_rd_addr), 32'd3);
      tick();
      @(negedge i_clk);
      chk("drain_addr4",  32'(o_rd_addr), 32'd4);
      chk("drain_count1", 32'(o_fifo_count), 32'd1);
      tick();
      @(negedge i_clk);
      chk("drain_count0", 32'(o_fifo_count), 32'd0);
      chk("drain_wren0",  32'(o_rd_wren), 32'd0);

      // Streaming with WB idle: pointers wrap, occupancy stays at most one.
      for (int i = 0; i < 6; i++) begin
         tick();
         llu(5'(16 + i), 32'h0000_1000 + 32'(i));
         @(negedge i_clk);
         chk("wrap_count", 32'(o_fifo_count), (i == 0) ? 32'd0 : 32'd1);
      end
      tick();
      idle();
      @(negedge i_clk);
      chk("wrap_last_wren", 32'(o_rd_wren), 32'd1);
      tick();
      @(negedge i_clk);
      chk("wrap_count0", 32'(o_fifo_count), 32'd0);

      // Set beats clear on x9.
      i_issue_valid = 1'b1; i_issue_rd = 5'd9;
      tick();
      i_issue_valid = 1'b0; i_rs1_addr = 5'd9;
      llu(5'd9, 32'h0000_0099);
      @(negedge i_clk);
      chk("sw_busy_pre", 32'(o_busy_rs1), 32'd1);
      tick();
      i_llu_valid = 1'b0;
      i_issue_valid = 1'b1; i_issue_rd = 5'd9;
      @(negedge i_clk);
      chk("sw_busy_pop", 32'(o_busy_rs1), 32'd0);
      tick();
      idle();
      @(negedge i_clk);
      chk("sw_pend9", 32'(o_pending[9]), 32'd1);
      chk("sw_busy",  32'(o_busy_rs1), 32'd1);
      llu(5'd9, 32'h0000_0098);
      tick();
      idle();
      tick();
      @(negedge i_clk);
      chk("sw_pend9_clr", 32'(o_pending[9]), 32'd0);

      // Issue to x0 leaves the scoreboard alone.
      i_issue_valid = 1'b1; i_issue_rd = 5'd12;
      tick();
      i_issue_rd = 5'd0; i_rs1_addr = 5'd0; i_rs2_addr = 5'd12;
      tick();
      idle();
      @(negedge i_clk);
      chk("x0_pend",  o_pending, 32'h0000_1000);
      chk("x0_busy1", 32'(o_busy_rs1), 32'd0);
      chk("x0_busy2", 32'(o_busy_rs2), 32'd1);

      // Reset mid-operation discards the buffered result (no expectation queued for it).
      i_llu_valid = 1'b1; i_llu_rd = 5'd2; i_llu_data = 32'h0000_0022;
      wb(5'd1, 32'h0000_0001);
      tick();
      idle();
      i_reset = 1'b0;
      #1;
      chk("mrst_count", 32'(o_fifo_count), 32'd0);
      chk("mrst_pend",  o_pending, 32'd0);
      chk("mrst_ready", 32'(o_llu_ready), 32'd0);
      tick();
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("mrst_wren",  32'(o_rd_wren), 32'd0);
      chk("mrst_ready1", 32'(o_llu_ready), 32'd1);
      tick();

      chk("wb_q_left",  32'(wb_q.size()), 32'd0);
      chk("llu_q_left", 32'(llu_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
